exibe_sequencia_ctrl: RTL and testbench

EXIBE_SEQUENCIA_CTRL -- requirements
Module: exibe_sequencia_ctrl

---
 rtl/exibe_sequencia_ctrl.sv | 128 ++++++++++++
 tb/tb_exibe_sequencia_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/exibe_sequencia_ctrl.sv
// Sequence display controller: steps through a sequence ROM and shows each word
// on the LEDs for T_ON cycles, followed by T_OFF dark cycles, up to the captured limit.
module exibe_sequencia_ctrl #(
  parameter int unsigned T_ON  = 4,
  parameter int unsigned T_OFF = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [3:0] limite,
  input  logic [6:0] memoria_dado,
  output logic [3:0] endereco,
  output logic [6:0] leds,
  output logic       ocupado,
  output logic       fim
);

  localparam int unsigned TW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 7;

  localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    CARREGA,
    ACESO,
    APAGADO,
    FIM
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [AW-1:0]   lim_reg, lim_n;
  logic [AW-1:0]   endereco_n;
  logic [DW-1:0]   leds_n;
  logic            ocupado_n, fim_n;

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= OCIOSO;
      timer    <= '0;
      lim_reg  <= '0;
      endereco <= '0;
      leds     <= '0;
      ocupado  <= 1'b0;
      fim      <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      lim_reg  <= lim_n;
      endereco <= endereco_n;
      leds     <= leds_n;
      ocupado  <= ocupado_n;
      fim      <= fim_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    lim_n      = lim_reg;
    endereco_n = endereco;
    leds_n     = leds;

    unique case (state)
      OCIOSO: begin
        leds_n = '0;
        if (iniciar && !abortar) begin
          state_n    = CARREGA;
          endereco_n = '0;
          lim_n      = limite;
        end
      end
      CARREGA: begin
        state_n = ACESO;
        leds_n  = memoria_dado;
        timer_n = '0;
      end
      ACESO: begin
        if (timer == ON_LAST) begin
          state_n = APAGADO;
          leds_n  = '0;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      APAGADO: begin
        leds_n = '0;
        if (timer == OFF_LAST) begin
          timer_n = '0;
          if (endereco == lim_reg) begin
            state_n = FIM;
          end else begin
            state_n    = CARREGA;
            endereco_n = endereco + AW'(1);
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      FIM: begin
        state_n = OCIOSO;
        leds_n  = '0;
      end
      default: begin
        state_n = OCIOSO;
        leds_n  = '0;
      end
    endcase

    // Cancel drops straight to idle, keeping the address where it stopped
    if (abortar && (state != OCIOSO)) begin
      state_n    = OCIOSO;
      leds_n     = '0;
      endereco_n = endereco;
    end

    ocupado_n = (state_n != OCIOSO);
    fim_n     = (state_n == FIM);
  end

endmodule

// File: tb/tb_exibe_sequencia_ctrl.sv
// Scoreboard bench for exibe_sequencia_ctrl: a cycle-position reference model pushes
// expected outputs, a negedge monitor pops and compares them against the DUT.
module tb_exibe_sequencia_ctrl;

  localparam int unsigned T_ON  = 4;
  localparam int unsigned T_OFF = 2;
  localparam int          P     = 1 + T_ON + T_OFF;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       abortar = 1'b0;
  logic [3:0] limite = 4'd0;
  logic [6:0] memoria_dado;
  logic [3:0] endereco;
  logic [6:0] leds;
  logic       ocupado;
  logic       fim;

  logic [6:0] rom [16];

  int n_total = 0;
  int n_bad   = 0;

  exibe_sequencia_ctrl #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .abortar      (abortar),
    .limite       (limite),
    .memoria_dado (memoria_dado),
    .endereco     (endereco),
    .leds         (leds),
    .ocupado      (ocupado),
    .fim          (fim)
  );

  always #5 clock = ~clock;

  assign memoria_dado = rom[endereco];

  initial begin
    rom[0] = 7'h01; rom[1] = 7'h02; rom[2] = 7'h04; rom[3] = 7'h08;
    for (int i = 4; i < 16; i++) rom[i] = 7'((i * 11 + 3) % 128);
  end

  // Expected output packed as {endereco, leds, ocupado, fim}
  logic [12:0] exp_q [$];

  bit          m_active = 1'b0;
  int          m_k      = 0;
  int          m_lim    = 0;
  int          m_total  = 0;
  logic [3:0]  m_end    = 4'd0;
  logic [12:0] m_e;

  // Outputs for cycle k of a playback (k = 0 is the first load cycle)
  function automatic logic [12:0] exp_at(input int k, input int lim, input int total);
    int step, ph;
    logic [6:0] l;
    if (k == total) return {4'(lim), 7'd0, 1'b1, 1'b1};
    step = k / P;
    ph   = k % P;
    l    = (ph >= 1 && ph <= int'(T_ON)) ? rom[step] : 7'd0;
    return {4'(step), l, 1'b1, 1'b0};
  endfunction

  // Reference model: decides the next cycle's outputs from the inputs seen at this edge
  always @(posedge clock) begin
    if (reset) begin
      m_active = 1'b0;
      m_e      = 13'd0;
    end else if (m_active) begin
      if (abortar || m_k == m_total) begin
        m_active = 1'b0;
        m_e      = {m_end, 9'd0};
      end else begin
        m_k = m_k + 1;
        m_e = exp_at(m_k, m_lim, m_total);
      end
    end else if (iniciar && !abortar) begin
      m_active = 1'b1;
      m_lim    = int'(limite);
      m_total  = (m_lim + 1) * P;
      m_k      = 0;
      m_e      = exp_at(0, m_lim, m_total);
    end else begin
      m_e = {m_end, 9'd0};
    end
    m_end = m_e[12:9];
    exp_q.push_back(m_e);
  end

  // Monitor: one comparison per presented cycle
  always @(negedge clock) begin
    logic [12:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {endereco, leds, ocupado, fim};
      n_total++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t got end=%0h leds=%0h oc=%0b fim=%0b, want end=%0h leds=%0h oc=%0b fim=%0b",
                 $time, a[12:9], a[8:2], a[1], a[0], e[12:9], e[8:2], e[1], e[0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);

    // Three-step playback
    limite = 4'd2;
    pulse_start();
    tick(30);

    // Single step
    limite = 4'd0;
    pulse_start();
    tick(12);

    // Full sixteen steps, limite changed mid-run
    limite = 4'd15;
    pulse_start();
    tick(50);
    limite = 4'd1;
    tick(80);

    // Abort in cycle 10, then restart
    limite = 4'd2;
    pulse_start();
    tick(9);
    abortar = 1'b1;
    tick(1);
    abortar = 1'b0;
    tick(5);
    pulse_start();
    tick(30);

    // iniciar held through a playback
    iniciar = 1'b1;
    tick(20);
    iniciar = 1'b0;
    tick(10);

    // Reset during step 1 on-time
    pulse_start();
    tick(10);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(15);

    // abortar beats iniciar in idle
    iniciar = 1'b1;
    abortar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    abortar = 1'b0;
    tick(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      iniciar = ($urandom % 8) == 0;
      abortar = ($urandom % 64) == 0;
      reset   = ($urandom % 250) == 0;
      limite  = 4'($urandom_range(0, 15));
      tick(1);
    end
    iniciar = 1'b0;
    abortar = 1'b0;
    reset   = 1'b0;
    tick(130);

    @(negedge clock);
    #1;
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
